// File: rtl/byteswap_arbiter.sv
// byteswap_arbiter
// Two-requester packet arbiter that feeds a shared stream into the byteswap
// swapper. Whole packets are granted round-robin, there is one bubble cycle
// between packets, and the output is a single register stage. It also counts
// the packets forwarded from each requester.
module byteswap_arbiter #(
  parameter int C_AXIS_TDATA_WIDTH = 512,
  parameter int C_CNT_WIDTH        = 32
) (
  input  logic                            s_axis_aclk,
  input  logic                            s_axis_areset,

  input  logic                            s0_axis_tvalid,
  output logic                            s0_axis_tready,
  input  logic [C_AXIS_TDATA_WIDTH-1:0]   s0_axis_tdata,
  input  logic [C_AXIS_TDATA_WIDTH/8-1:0] s0_axis_tkeep,
  input  logic                            s0_axis_tlast,

  input  logic                            s1_axis_tvalid,
  output logic                            s1_axis_tready,
  input  logic [C_AXIS_TDATA_WIDTH-1:0]   s1_axis_tdata,
  input  logic [C_AXIS_TDATA_WIDTH/8-1:0] s1_axis_tkeep,
  input  logic                            s1_axis_tlast,

  output logic                            m_axis_tvalid,
  input  logic                            m_axis_tready,
  output logic [C_AXIS_TDATA_WIDTH-1:0]   m_axis_tdata,
  output logic [C_AXIS_TDATA_WIDTH/8-1:0] m_axis_tkeep,
  output logic                            m_axis_tlast,
  output logic                            m_axis_tdest,

  output logic [C_CNT_WIDTH-1:0]          pkt_cnt0,
  output logic [C_CNT_WIDTH-1:0]          pkt_cnt1
);

  localparam int KW = C_AXIS_TDATA_WIDTH / 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_t;

  state_t                          state_r;
  state_t                          next_state_s;
  logic                            rr_r;
  logic                            out_ready_s;
  logic                            accept_s;
  logic                            accept_last_s;
  logic [C_AXIS_TDATA_WIDTH-1:0]   sel_data_s;
  logic [KW-1:0]                   sel_keep_s;
  logic                            sel_last_s;
  logic                            sel_dest_s;
  logic [C_CNT_WIDTH-1:0]          cnt_one_s;

  // The output register can take a new beat when empty or being drained;
  // reset blocks acceptance so no beat slips in while reset is held.
  assign out_ready_s   = ~s_axis_areset & (~m_axis_tvalid | m_axis_tready);
  assign accept_last_s = accept_s & sel_last_s;
  assign cnt_one_s     = {{(C_CNT_WIDTH-1){1'b0}}, 1'b1};

  // State register: arbitration result takes effect at the next edge
  always_ff @(posedge s_axis_aclk) begin
    if (s_axis_areset) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic: arbitrate in IDLE, hold the grant until the tlast beat
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (s0_axis_tvalid && s1_axis_tvalid) begin
          next_state_s = rr_r ? GRANT1 : GRANT0;
        end else if (s0_axis_tvalid) begin
          next_state_s = GRANT0;
        end else if (s1_axis_tvalid) begin
          next_state_s = GRANT1;
        end else begin
          next_state_s = IDLE;
        end
      end
      GRANT0, GRANT1: begin
        if (accept_last_s) begin
          next_state_s = IDLE;
        end else begin
          next_state_s = state_r;
        end
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  // Output decode: steer the granted requester and drive its tready
  always_comb begin
    s0_axis_tready = 1'b0;
    s1_axis_tready = 1'b0;
    accept_s       = 1'b0;
    sel_data_s     = s0_axis_tdata;
    sel_keep_s     = s0_axis_tkeep;
    sel_last_s     = s0_axis_tlast;
    sel_dest_s     = 1'b0;
    case (state_r)
      GRANT0: begin
        s0_axis_tready = out_ready_s;
        accept_s       = s0_axis_tvalid & out_ready_s;
      end
      GRANT1: begin
        s1_axis_tready = out_ready_s;
        accept_s       = s1_axis_tvalid & out_ready_s;
        sel_data_s     = s1_axis_tdata;
        sel_keep_s     = s1_axis_tkeep;
        sel_last_s     = s1_axis_tlast;
        sel_dest_s     = 1'b1;
      end
      default: begin
        s0_axis_tready = 1'b0;
        s1_axis_tready = 1'b0;
        accept_s       = 1'b0;
      end
    endcase
  end

  // Round-robin pointer: after a packet completes, prefer the other requester
  always_ff @(posedge s_axis_aclk) begin
    if (s_axis_areset) begin
      rr_r <= 1'b0;
    end else if (accept_last_s) begin
      rr_r <= ~sel_dest_s;
    end else begin
      rr_r <= rr_r;
    end
  end

  // Output control register: valid/last/dest, held while stalled
  always_ff @(posedge s_axis_aclk) begin
    if (s_axis_areset) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tdest  <= 1'b0;
    end else if (accept_s) begin
      m_axis_tvalid <= 1'b1;
      m_axis_tlast  <= sel_last_s;
      m_axis_tdest  <= sel_dest_s;
    end else if (m_axis_tready) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= m_axis_tlast;
      m_axis_tdest  <= m_axis_tdest;
    end else begin
      m_axis_tvalid <= m_axis_tvalid;
      m_axis_tlast  <= m_axis_tlast;
      m_axis_tdest  <= m_axis_tdest;
    end
  end

  // Output payload register: wide datapath is left unreset on purpose
  always_ff @(posedge s_axis_aclk) begin
    if (accept_s) begin
      m_axis_tdata <= sel_data_s;
      m_axis_tkeep <= sel_keep_s;
    end else begin
      m_axis_tdata <= m_axis_tdata;
      m_axis_tkeep <= m_axis_tkeep;
    end
  end

  // Per-requester packet counters, wrapping naturally at full scale
  always_ff @(posedge s_axis_aclk) begin
    if (s_axis_areset) begin
      pkt_cnt0 <= '0;
      pkt_cnt1 <= '0;
    end else if (accept_last_s && !sel_dest_s) begin
      pkt_cnt0 <= pkt_cnt0 + cnt_one_s;
      pkt_cnt1 <= pkt_cnt1;
    end else if (accept_last_s && sel_dest_s) begin
      pkt_cnt0 <= pkt_cnt0;
      pkt_cnt1 <= pkt_cnt1 + cnt_one_s;
    end else begin
      pkt_cnt0 <= pkt_cnt0;
      pkt_cnt1 <= pkt_cnt1;
    end
  end

endmodule

// File: tb/tb_byteswap_arbiter.sv
// tb_byteswap_arbiter
// Scenario tasks plus randomized traffic. Sources push whole packets from
// queues; a monitor records every transferred output beat; the expected
// result is derived from the packet-level rules (per-source order, whole
// packets, round-robin, counters modulo 2^CW).
module tb_byteswap_arbiter;

  localparam int W  = 64;
  localparam int KW = W / 8;
  localparam int CW = 4;

  typedef struct packed {
    logic [W-1:0]  data;
    logic [KW-1:0] keep;
    logic          last;
  } beat_t;

  typedef struct packed {
    logic [W-1:0]  data;
    logic [KW-1:0] keep;
    logic          last;
    logic          dest;
  } obeat_t;

  logic          clk = 1'b0;
  logic          areset;
  logic          s0_axis_tvalid, s0_axis_tready, s0_axis_tlast;
  logic [W-1:0]  s0_axis_tdata;
  logic [KW-1:0] s0_axis_tkeep;
  logic          s1_axis_tvalid, s1_axis_tready, s1_axis_tlast;
  logic [W-1:0]  s1_axis_tdata;
  logic [KW-1:0] s1_axis_tkeep;
  logic          m_axis_tvalid, m_axis_tready, m_axis_tlast, m_axis_tdest;
  logic [W-1:0]  m_axis_tdata;
  logic [KW-1:0] m_axis_tkeep;
  logic [CW-1:0] pkt_cnt0, pkt_cnt1;

  int     checks   = 0;
  int     failures = 0;
  int     ready_ctl = 1;   // 0: hold low, 1: hold high, 2: random
  bit     gap_en = 1'b0;
  logic   hs0 = 1'b0;
  logic   hs1 = 1'b0;
  beat_t  src0_q[$];
  beat_t  src1_q[$];
  beat_t  exp0_q[$];
  beat_t  exp1_q[$];
  obeat_t out_q[$];

  always #5 clk = ~clk;

  byteswap_arbiter #(
    .C_AXIS_TDATA_WIDTH(W),
    .C_CNT_WIDTH(CW)
  ) dut (
    .s_axis_aclk(clk),
    .s_axis_areset(areset),
    .s0_axis_tvalid(s0_axis_tvalid),
    .s0_axis_tready(s0_axis_tready),
    .s0_axis_tdata(s0_axis_tdata),
    .s0_axis_tkeep(s0_axis_tkeep),
    .s0_axis_tlast(s0_axis_tlast),
    .s1_axis_tvalid(s1_axis_tvalid),
    .s1_axis_tready(s1_axis_tready),
    .s1_axis_tdata(s1_axis_tdata),
    .s1_axis_tkeep(s1_axis_tkeep),
    .s1_axis_tlast(s1_axis_tlast),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .m_axis_tdata(m_axis_tdata),
    .m_axis_tkeep(m_axis_tkeep),
    .m_axis_tlast(m_axis_tlast),
    .m_axis_tdest(m_axis_tdest),
    .pkt_cnt0(pkt_cnt0),
    .pkt_cnt1(pkt_cnt1)
  );

  // Record input handshakes and transferred output beats at each edge
  always @(posedge clk) begin
    hs0 <= s0_axis_tvalid & s0_axis_tready;
    hs1 <= s1_axis_tvalid & s1_axis_tready;
    if (!areset && m_axis_tvalid && m_axis_tready)
      out_q.push_back({m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tdest});
  end

  // Source 0: present queue head, hold it until accepted
  initial begin
    s0_axis_tvalid = 1'b0; s0_axis_tdata = '0; s0_axis_tkeep = '0; s0_axis_tlast = 1'b0;
    forever begin
      @(negedge clk);
      if (hs0 && src0_q.size() > 0) void'(src0_q.pop_front());
      if (src0_q.size() == 0) s0_axis_tvalid = 1'b0;
      else if (!(s0_axis_tvalid && !hs0)) s0_axis_tvalid = (!gap_en) || ($urandom_range(0, 3) != 0);
      if (s0_axis_tvalid) {s0_axis_tdata, s0_axis_tkeep, s0_axis_tlast} = src0_q[0];
    end
  end

  // Source 1: present queue head, hold it until accepted
  initial begin
    s1_axis_tvalid = 1'b0; s1_axis_tdata = '0; s1_axis_tkeep = '0; s1_axis_tlast = 1'b0;
    forever begin
      @(negedge clk);
      if (hs1 && src1_q.size() > 0) void'(src1_q.pop_front());
      if (src1_q.size() == 0) s1_axis_tvalid = 1'b0;
      else if (!(s1_axis_tvalid && !hs1)) s1_axis_tvalid = (!gap_en) || ($urandom_range(0, 3) != 0);
      if (s1_axis_tvalid) {s1_axis_tdata, s1_axis_tkeep, s1_axis_tlast} = src1_q[0];
    end
  end

  // Downstream ready generator
  initial begin
    m_axis_tready = 1'b1;
    forever begin
      @(negedge clk);
      case (ready_ctl)
        0:       m_axis_tready = 1'b0;
        1:       m_axis_tready = 1'b1;
        default: m_axis_tready = ($urandom_range(0, 2) != 0);
      endcase
    end
  end

  // Global time limit
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  function automatic beat_t rand_beat(input logic last);
    beat_t b;
    b.data = {$urandom(), $urandom()};
    b.keep = KW'($urandom_range(0, 255));
    b.last = last;
    return b;
  endfunction

  task automatic push_pkt(input int src, input int len);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      b = rand_beat(i == len - 1);
      if (src == 0) begin src0_q.push_back(b); exp0_q.push_back(b); end
      else begin src1_q.push_back(b); exp1_q.push_back(b); end
    end
  endtask

  task automatic do_reset();
    ready_ctl = 1; gap_en = 1'b0;
    src0_q.delete(); src1_q.delete(); exp0_q.delete(); exp1_q.delete();
    areset = 1'b1;
    repeat (2) tick();
    areset = 1'b0;
    out_q.delete();
  endtask

  task automatic test_reset();
    areset = 1'b1;
    push_pkt(0, 2);
    push_pkt(1, 2);
    repeat (3) tick();
    checks++; if (m_axis_tvalid !== 1'b0) begin failures++; $display("FAIL reset_tvalid: got %b expected 0", m_axis_tvalid); end
    checks++; if (m_axis_tdest !== 1'b0) begin failures++; $display("FAIL reset_tdest: got %b expected 0", m_axis_tdest); end
    checks++; if (m_axis_tlast !== 1'b0) begin failures++; $display("FAIL reset_tlast: got %b expected 0", m_axis_tlast); end
    checks++; if (pkt_cnt0 !== 4'd0 || pkt_cnt1 !== 4'd0) begin failures++; $display("FAIL reset_cnt: got %0d/%0d expected 0/0", pkt_cnt0, pkt_cnt1); end
    checks++; if (s0_axis_tready !== 1'b0 || s1_axis_tready !== 1'b0) begin failures++; $display("FAIL reset_tready: got %b%b expected 00", s0_axis_tready, s1_axis_tready); end
    // both valid at release: first edge with reset low grants requester 0
    areset = 1'b0;
    tick();
    checks++; if ({s0_axis_tready, s1_axis_tready} !== 2'b10) begin failures++; $display("FAIL reset_first_arb: got %b%b expected 10", s0_axis_tready, s1_axis_tready); end
  endtask

  task automatic test_single_packet();
    obeat_t e;
    do_reset();
    push_pkt(0, 4);
    tick();
    checks++; if ({m_axis_tvalid, s0_axis_tready} !== 2'b01) begin failures++; $display("FAIL single_bubble: got %b%b expected 01", m_axis_tvalid, s0_axis_tready); end
    for (int i = 0; i < 4; i++) begin
      tick();
      e = {exp0_q[i], 1'b0};
      checks++;
      if ({m_axis_tvalid, s1_axis_tready, m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tdest} !== {2'b10, e}) begin
        failures++;
        $display("FAIL single_beat%0d: got %0h expected %0h", i, {m_axis_tvalid, s1_axis_tready, m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tdest}, {2'b10, e});
      end
    end
    tick();
    checks++; if (m_axis_tvalid !== 1'b0) begin failures++; $display("FAIL single_end_valid: got %b expected 0", m_axis_tvalid); end
    checks++; if (pkt_cnt0 !== 4'd1 || pkt_cnt1 !== 4'd0) begin failures++; $display("FAIL single_cnt: got %0d/%0d expected 1/0", pkt_cnt0, pkt_cnt1); end
    checks++; if (out_q.size() != 4) begin failures++; $display("FAIL single_count: got %0d expected 4", out_q.size()); end
  endtask

  task automatic test_alternation();
    obeat_t ob;
    beat_t  eb;
    logic   ev, ed;
    do_reset();
    push_pkt(0, 2); push_pkt(0, 2);
    push_pkt(1, 2); push_pkt(1, 2);
    // each packet = one bubble cycle then two beats; owners alternate 0,1,0,1
    for (int k = 0; k < 12; k++) begin
      tick();
      ev = ((k % 3) != 0);
      ed = ((k / 3) % 2) != 0;
      checks++;
      if (m_axis_tvalid !== ev || (ev && m_axis_tdest !== ed)) begin
        failures++;
        $display("FAIL alt_cycle%0d: got v=%b d=%b expected v=%b d=%b", k, m_axis_tvalid, m_axis_tdest, ev, ed);
      end
    end
    tick();
    checks++; if (pkt_cnt0 !== 4'd2 || pkt_cnt1 !== 4'd2) begin failures++; $display("FAIL alt_cnt: got %0d/%0d expected 2/2", pkt_cnt0, pkt_cnt1); end
    checks++; if (out_q.size() != 8) begin failures++; $display("FAIL alt_count: got %0d expected 8", out_q.size()); end
    while (out_q.size() > 0) begin
      ob = out_q.pop_front();
      if (ob.dest) eb = (exp1_q.size() > 0) ? exp1_q.pop_front() : '0;
      else         eb = (exp0_q.size() > 0) ? exp0_q.pop_front() : '0;
      checks++;
      if ({ob.data, ob.keep, ob.last} !== eb) begin failures++; $display("FAIL alt_data: got %0h expected %0h", {ob.data, ob.keep, ob.last}, eb); end
    end
  endtask

  task automatic test_stall();
    obeat_t e;
    do_reset();
    push_pkt(0, 4);
    repeat (3) tick();   // beat 1 now in the output register
    ready_ctl = 0;
    e = {exp0_q[1], 1'b0};
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if ({m_axis_tvalid, s0_axis_tready, m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tdest} !== {2'b10, e}) begin
        failures++;
        $display("FAIL stall_hold%0d: got %0h expected %0h", i, {m_axis_tvalid, s0_axis_tready, m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tdest}, {2'b10, e});
      end
    end
    ready_ctl = 1;
    for (int i = 0; i < 20 && out_q.size() < 4; i++) tick();
    repeat (3) tick();
    checks++; if (out_q.size() != 4) begin failures++; $display("FAIL stall_count: got %0d expected 4", out_q.size()); end
    for (int i = 0; i < 4 && i < out_q.size(); i++) begin
      e = {exp0_q[i], 1'b0};
      checks++; if (out_q[i] !== e) begin failures++; $display("FAIL stall_beat%0d: got %0h expected %0h", i, out_q[i], e); end
    end
  endtask

  task automatic test_no_preempt();
    obeat_t e;
    do_reset();
    push_pkt(0, 3);
    repeat (2) tick();   // beat 1 of s0 is being presented next
    push_pkt(1, 2);
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++; if (s1_axis_tready !== 1'b0) begin failures++; $display("FAIL nopre_s1_ready%0d: got %b expected 0", i, s1_axis_tready); end
    end
    tick();
    checks++; if ({m_axis_tvalid, s1_axis_tready} !== 2'b01) begin failures++; $display("FAIL nopre_grant1: got %b%b expected 01", m_axis_tvalid, s1_axis_tready); end
    for (int i = 0; i < 20 && out_q.size() < 5; i++) tick();
    repeat (2) tick();
    checks++; if (out_q.size() != 5) begin failures++; $display("FAIL nopre_count: got %0d expected 5", out_q.size()); end
    for (int i = 0; i < 5 && i < out_q.size(); i++) begin
      e = (i < 3) ? {exp0_q[i], 1'b0} : {exp1_q[i-3], 1'b1};
      checks++; if (out_q[i] !== e) begin failures++; $display("FAIL nopre_beat%0d: got %0h expected %0h", i, out_q[i], e); end
    end
  endtask

  task automatic test_reset_mid();
    obeat_t e;
    do_reset();
    push_pkt(0, 3);
    repeat (2) tick();   // beat 0 out, beat 1 on the input
    areset = 1'b1;
    tick();
    checks++; if (m_axis_tvalid !== 1'b0) begin failures++; $display("FAIL rmid_tvalid: got %b expected 0", m_axis_tvalid); end
    checks++; if (pkt_cnt0 !== 4'd0 || pkt_cnt1 !== 4'd0) begin failures++; $display("FAIL rmid_cnt: got %0d/%0d expected 0/0", pkt_cnt0, pkt_cnt1); end
    checks++; if (s0_axis_tready !== 1'b0) begin failures++; $display("FAIL rmid_tready: got %b expected 0", s0_axis_tready); end
    src0_q.delete();
    areset = 1'b0;
    push_pkt(1, 1);
    tick();
    // an IDLE FSM grants s1 at the first edge after reset, with a bubble
    checks++; if ({m_axis_tvalid, s0_axis_tready, s1_axis_tready} !== 3'b001) begin failures++; $display("FAIL rmid_idle: got %b%b%b expected 001", m_axis_tvalid, s0_axis_tready, s1_axis_tready); end
    tick();
    e = {exp1_q[0], 1'b1};
    checks++; if ({m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tdest} !== {1'b1, e}) begin failures++; $display("FAIL rmid_single: got %0h expected %0h", {m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tdest}, {1'b1, e}); end
    checks++; if (pkt_cnt0 !== 4'd0 || pkt_cnt1 !== 4'd1) begin failures++; $display("FAIL rmid_cnt_after: got %0d/%0d expected 0/1", pkt_cnt0, pkt_cnt1); end
    repeat (3) tick();
    checks++; if (out_q.size() != 1) begin failures++; $display("FAIL rmid_count: got %0d expected 1", out_q.size()); end
  endtask

  task automatic test_counter_wrap();
    int sent = 0;
    int n;
    int i;
    do_reset();
    for (int r = 0; r < 3; r++) begin
      n = (r == 0) ? 15 : 1;
      for (int p = 0; p < n; p++) push_pkt(0, $urandom_range(1, 3));
      sent += n;
      for (i = 0; i < 400 && (src0_q.size() > 0 || m_axis_tvalid); i++) tick();
      checks++; if (i >= 400) begin failures++; $display("FAIL wrap_timeout%0d: got timeout expected drain", r); end
      repeat (2) tick();
      checks++; if (pkt_cnt0 !== CW'(sent % 16) || pkt_cnt1 !== 4'd0) begin failures++; $display("FAIL wrap_cnt%0d: got %0d/%0d expected %0d/0", r, pkt_cnt0, pkt_cnt1, sent % 16); end
    end
  endtask

  task automatic test_random();
    int     np0 = 0, np1 = 0, i;
    int     src;
    obeat_t ob;
    beat_t  eb;
    logic   in_pkt = 1'b0, cur = 1'b0;
    do_reset();
    gap_en = 1'b1; ready_ctl = 2;
    for (int p = 0; p < 40; p++) begin
      src = $urandom_range(0, 1);
      push_pkt(src, $urandom_range(1, 4));
      if (src == 0) np0++; else np1++;
    end
    for (i = 0; i < 3000 && (src0_q.size() > 0 || src1_q.size() > 0 || m_axis_tvalid); i++) tick();
    checks++; if (i >= 3000) begin failures++; $display("FAIL rand_timeout: got timeout expected drain"); end
    ready_ctl = 1; gap_en = 1'b0;
    repeat (3) tick();
    while (out_q.size() > 0) begin
      ob = out_q.pop_front();
      if (ob.dest) eb = (exp1_q.size() > 0) ? exp1_q.pop_front() : '0;
      else         eb = (exp0_q.size() > 0) ? exp0_q.pop_front() : '0;
      checks++;
      if ({ob.data, ob.keep, ob.last} !== eb || (in_pkt && ob.dest !== cur)) begin
        failures++;
        $display("FAIL rand_beat: got d=%b %0h expected d=%b %0h", ob.dest, {ob.data, ob.keep, ob.last}, in_pkt ? cur : ob.dest, eb);
      end
      cur = ob.dest;
      in_pkt = !ob.last;
    end
    checks++; if (exp0_q.size() != 0 || exp1_q.size() != 0) begin failures++; $display("FAIL rand_lost: got %0d/%0d left expected 0/0", exp0_q.size(), exp1_q.size()); end
    checks++; if (pkt_cnt0 !== CW'(np0 % 16) || pkt_cnt1 !== CW'(np1 % 16)) begin failures++; $display("FAIL rand_cnt: got %0d/%0d expected %0d/%0d", pkt_cnt0, pkt_cnt1, np0 % 16, np1 % 16); end
  endtask

  initial begin
    areset = 1'b1;
    test_reset();
    test_single_packet();
    test_alternation();
    test_stall();
    test_no_preempt();
    test_reset_mid();
    test_counter_wrap();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/byteswap_arbiter.md
BYTESWAP_ARBITER -- requirements
Module: byteswap_arbiter

Interface
REQ-001 SHALL have parameter C_AXIS_TDATA_WIDTH, default 512, meaning data width of all streams in bits (multiple of 8).
REQ-002 SHALL have parameter C_CNT_WIDTH, default 32, meaning width of each per-port packet counter.
REQ-003 SHALL have port s_axis_aclk  input  1  the single clock for all interfaces.
REQ-004 SHALL have port s_axis_areset  input  1  synchronous, active-high reset.
REQ-005 SHALL have ports s0_axis_tvalid/tready/tdata/tkeep/tlast  in/out/in/in/in  1/1/W/W/8/1  requester 0 stream.
REQ-006 SHALL have ports s1_axis_tvalid/tready/tdata/tkeep/tlast  in/out/in/in/in  1/1/W/W/8/1  requester 1 stream.
REQ-007 SHALL have ports m_axis_tvalid/tready/tdata/tkeep/tlast  out/in/out/out/out  1/1/W/W/8/1  shared stream into the byteswap swapper.
REQ-008 SHALL have port m_axis_tdest  output  1  index of the requester that sourced the current output beat.
REQ-009 SHALL have ports pkt_cnt0, pkt_cnt1  output  C_CNT_WIDTH  packets forwarded from requester 0 and from requester 1.

Function
REQ-010 SHALL implement FSM states IDLE, GRANT0 and GRANT1, with state held in a register.
REQ-011 SHALL keep a one-bit round-robin pointer rr naming the preferred requester; rr is 0 out of reset.
REQ-012 In IDLE: only s0 valid -> GRANT0; only s1 valid -> GRANT1; both valid -> GRANTrr; neither -> stay in IDLE.
REQ-013 In IDLE, no beat SHALL be accepted and both s*_axis_tready SHALL be 0.
REQ-014 The arbitration decision SHALL take effect at the next clock edge, giving exactly one bubble cycle between packets.
REQ-015 In GRANTx, sx_axis_tready SHALL be (!m_axis_tvalid | m_axis_tready), and the non-granted tready SHALL be 0.
REQ-016 A beat is accepted when the granted sx_axis_tvalid and sx_axis_tready are both 1 in the same cycle.
REQ-017 An accepted beat SHALL load the output register (tdata, tkeep, tlast, tdest=x) and set m_axis_tvalid=1 at the next edge, for a latency of 1 cycle.
REQ-018 m_axis_tvalid SHALL clear at an edge where m_axis_tready=1 and no new beat is accepted.
REQ-019 Output register contents SHALL NOT change while m_axis_tvalid=1 and m_axis_tready=0.
REQ-020 Accepting a beat with tlast=1 in GRANTx SHALL return the FSM to IDLE, set rr to !x, and increment pkt_cntx by 1.
REQ-021 Grant SHALL never change mid-packet, regardless of the other requester's tvalid.
REQ-022 Throughput within a packet SHALL be one beat per cycle while m_axis_tready=1.
REQ-023 Packet counters SHALL wrap modulo 2^C_CNT_WIDTH without saturating.
REQ-024 A single-beat packet (tlast on the first beat) SHALL be handled identically to a multi-beat packet.
REQ-025 tkeep SHALL pass through unmodified, and tdata SHALL pass through unmodified (swapping is done downstream).

Reset
REQ-026 While s_axis_areset=1, at each edge: state=IDLE, rr=0, m_axis_tvalid=0, pkt_cnt0=pkt_cnt1=0, m_axis_tdest=0, m_axis_tlast=0.
REQ-027 During reset, s0_axis_tready and s1_axis_tready SHALL be 0.
REQ-028 tdata and tkeep need not be reset.
REQ-029 Reset asserted mid-packet SHALL abandon the packet: no counter increment, and no further beats of it are forwarded.
REQ-030 After reset deasserts, the first arbitration SHALL occur in the first cycle with reset low.

Verification
REQ-031 The bench SHALL cover: s0 sends a 4-beat packet, s1 idle, m_tready=1 -> 4 output beats, tdest=0, tlast on beat 4, pkt_cnt0=1, first output 2 cycles after s0_tvalid.
REQ-032 The bench SHALL cover: s0 and s1 both continuously valid with 2-beat packets -> output packets alternate 0,1,0,1, one bubble between packets, equal counters after 4 packets.
REQ-033 The bench SHALL cover: m_tready=0 for 5 cycles mid-packet -> output beat held stable, granted tready=0, no beats lost or duplicated.
REQ-034 The bench SHALL cover: s1 asserts tvalid during beat 2 of a 3-beat s0 packet -> s1 is not granted until after s0's tlast beat; s1_tready=0 throughout.
REQ-035 The bench SHALL cover: reset asserted on beat 2 of a 3-beat packet -> m_tvalid=0 and counters 0 next cycle, with the FSM in IDLE.
REQ-036 The bench SHALL cover: pkt_cnt0 preloaded near 2^C_CNT_WIDTH-1 (or C_CNT_WIDTH=4 with 17 packets) -> counter wraps to 0, then 1.
